ov7670_sccb_sender: RTL
=======================

Name: ov7670_sccb_sender

Overview:
- Consumes the 16-bit {register address, value} command stream from the OV7670 register table and writes each entry to the camera over SCCB (3-phase write).
- Pulses advance after each write and stops when the table reports finished.
- Sits between the register table and the camera SIOC/SIOD pads. The top level builds the SIOD tristate from siod_o/siod_oe.

Parameters:
- QUARTER_DIV, 250, clk cycles per quarter SIOC period (100 kHz at 100 MHz)
- CAM_ID, 8'h42, SCCB write ID byte
- POWERUP_WAIT, 100000, idle cycles after reset/reconfig before first fetch
- CMD_GAP, 1000, idle cycles between writes
- RESET_WAIT, 1000000, idle cycles after a COM7 soft-reset write

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- reconfig  in  1  one-cycle pulse; restart whole table from entry 0
- command  in  16  [15:8] register address, [7:0] value; valid 2 cycles after resend/advance
- finished  in  1  table end marker (command==16'hFFFF)
- resend  out  1  one-cycle pulse; rewinds table to entry 0
- advance  out  1  one-cycle pulse; steps table to next entry
- sioc  out  1  SCCB clock, idles high
- siod_o  out  1  SCCB data drive value
- siod_oe  out  1  1 = drive siod_o; 0 = released (pull-up)
- busy  out  1  high from resend until config_done
- config_done  out  1  level; table fully written

Behaviour:
- Single clock. Reset is synchronous and active-high. All outputs are registered.
- Reset values: sioc=1, siod_o=1, siod_oe=0, resend=0, advance=0, busy=0, config_done=0, state=RESTART.
- Quarter tick: a counter runs 0..QUARTER_DIV-1 and ticks on wrap. It is cleared on every state entry.
- FSM states: RESTART, PWR_WAIT, FETCH, CHECK, START, BITS, STOP, STEP, GAP, DONE.
- RESTART: resend=1 for one cycle, busy=1, then go to PWR_WAIT.
- PWR_WAIT: count POWERUP_WAIT cycles, then go to FETCH.
- FETCH: wait exactly 2 cycles (table read latency), then go to CHECK.
- CHECK, finished=1: go to DONE. No SIOC/SIOD activity.
- CHECK, finished=0: load a 27-bit shift register with {CAM_ID, Z, command[15:8], Z, command[7:0], Z}, MSB first. Latch the COM7 flag (command[15:8]==8'h12 && command[7]). Go to START.
- START: one half-period with siod_oe=1, siod_o=1, sioc=1. Then siod_o=0 for one quarter with sioc=1. Then sioc=0. Go to BITS.
- BITS: each bit takes 4 quarters.
  - q0: sioc=0, update SIOD.
  - q1: sioc=0.
  - q2, q3: sioc=1.
  - Data bits: siod_oe=1, siod_o=bit.
  - Z bits (positions 9, 18, 27): siod_oe=0. The slave response is not checked; SCCB don't-care.
- STOP: q0 sioc=0, siod_oe=1, siod_o=0; q1 sioc=1; q2 siod_o=1; q3 siod_oe=0. Go to STEP.
- STEP: advance=1 for exactly one cycle. Go to GAP.
- GAP: count RESET_WAIT cycles if the COM7 flag is set, else CMD_GAP. Then go to FETCH.
- DONE: config_done=1, busy=0, bus idle (sioc=1, siod_oe=0). Hold indefinitely.
- reconfig pulse:
  - In DONE: go to RESTART (config_done clears the next cycle).
  - In any other state: ignored. Only one transaction is ever in flight.
- Reset mid-transaction: the bus is released immediately (the slave sees an aborted frame). The FSM restarts at RESTART, so resend re-issues and the whole table is rewritten.
- Boundaries:
  - advance is never asserted in the same cycle as resend.
  - command is sampled only in CHECK and ignored elsewhere.
  - Counters are sized with $clog2 of the largest wait parameter, so no wrap can occur before the terminal count.
  - QUARTER_DIV must be >= 2.

Decomposition:
- Package ov7670_pkg:
  - sccb_state_t enum
  - SCCB_FRAME_BITS=27
  - CMD_END=16'hFFFF
  - COM7_ADDR=8'h12
- Sub-module sccb_quarter_tick: parameterised divider with clear input and one-cycle tick output. FSM and shifting stay in the top module.

Test Plan:
- Write 16'h3A14 with QUARTER_DIV=4. Decode SIOD on SIOC rising edges and expect bytes 42, 3A, 14. Expect siod_oe=0 during the 3 Z bits and a correct START/STOP. Expect one advance pulse after STOP.
- finished=1 at the first CHECK -> config_done=1 and zero SIOC toggles after reset release. resend pulsed exactly once.
- Command 16'h1280 -> GAP lasts RESET_WAIT cycles before the next FETCH. Command 16'h1200 -> GAP lasts CMD_GAP cycles.
- Assert rst during the 12th bit -> next cycle sioc=1, siod_oe=0, advance=0. After release, resend pulses and the first frame is 42,12,80.
- Table model of 5 entries then FFFF -> exactly 5 frames and 5 advance pulses, then config_done. reconfig in DONE -> the 5 frames repeat.
- reconfig pulse mid-frame -> ignored; frame completes unchanged.

Source files
------------

// File: rtl/ov7670_sccb_sender_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ov7670_pkg
// Brief    : Shared types and constants for the OV7670 SCCB register writer.
// Revision : 1.0
// ============================================================================
package ov7670_pkg;

    typedef enum logic [3:0] {
        ST_RESTART  = 4'd0,
        ST_PWR_WAIT = 4'd1,
        ST_FETCH    = 4'd2,
        ST_CHECK    = 4'd3,
        ST_START    = 4'd4,
        ST_BITS     = 4'd5,
        ST_STOP     = 4'd6,
        ST_STEP     = 4'd7,
        ST_GAP      = 4'd8,
        ST_DONE     = 4'd9
    } sccb_state_t;

    localparam int          SCCB_FRAME_BITS = 27;
    localparam logic [15:0] CMD_END         = 16'hFFFF;
    localparam logic [7:0]  COM7_ADDR       = 8'h12;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ov7670_sccb_sender_if.sv
`default_nettype none
// ============================================================================
// Module   : ov7670_sccb_sender_if
// Brief    : Register-table handshake plus SCCB pad signals of the sender.
// Revision : 1.0
// ============================================================================
interface ov7670_sccb_sender_if;
    logic        reconfig;
    logic [15:0] command;
    logic        finished;
    logic        resend;
    logic        advance;
    logic        sioc;
    logic        siod_o;
    logic        siod_oe;
    logic        busy;
    logic        config_done;

    modport master (
        input  reconfig, command, finished,
        output resend, advance, sioc, siod_o, siod_oe, busy, config_done
    );

    modport slave (
        output reconfig, command, finished,
        input  resend, advance, sioc, siod_o, siod_oe, busy, config_done
    );
endinterface
`default_nettype wire

// File: rtl/ov7670_sccb_sender_quarter_tick.sv
`default_nettype none
// ============================================================================
// Module   : sccb_quarter_tick
// Brief    : Divider producing a one-cycle tick every QUARTER_DIV clocks.
// Revision : 1.0
// ============================================================================
module sccb_quarter_tick #(
    parameter int QUARTER_DIV = 250
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic clear_i,
    output logic      tick_o
);
    localparam int CW = (QUARTER_DIV > 1) ? $clog2(QUARTER_DIV) : 1;

    logic [CW-1:0] cnt_q;

    assign tick_o = (cnt_q == CW'(QUARTER_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst || clear_i || tick_o) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end
endmodule
`default_nettype wire

// File: rtl/ov7670_sccb_sender.sv
`default_nettype none
// ============================================================================
// Module   : ov7670_sccb_sender
// Brief    : Walks the OV7670 register table and writes each entry over SCCB.
// Revision : 1.0
// ============================================================================
module ov7670_sccb_sender
    import ov7670_pkg::*;
#(
    parameter int          QUARTER_DIV  = 250,
    parameter logic [7:0]  CAM_ID       = 8'h42,
    parameter int          POWERUP_WAIT = 100000,
    parameter int          CMD_GAP      = 1000,
    parameter int          RESET_WAIT   = 1000000
) (
    input  wire logic               clk,
    input  wire logic               rst,
    ov7670_sccb_sender_if.master    bus
);
    localparam int unsigned WAIT_MAX = max_u(max_u(POWERUP_WAIT, CMD_GAP), max_u(RESET_WAIT, 2));
    localparam int          WW       = $clog2(WAIT_MAX);

    localparam logic [WW-1:0] PW_LAST    = WW'(POWERUP_WAIT - 1);
    localparam logic [WW-1:0] FETCH_LAST = WW'(1);
    localparam logic [WW-1:0] CG_LAST    = WW'(CMD_GAP - 1);
    localparam logic [WW-1:0] RW_LAST    = WW'(RESET_WAIT - 1);
    localparam logic [4:0]    LAST_BIT   = 5'(SCCB_FRAME_BITS - 1);

    sccb_state_t   state_q, state_d;
    logic [WW-1:0] wait_q;
    logic [1:0]    qidx_q;
    logic [4:0]    bit_q;
    logic [26:0]   shreg_q;
    logic          com7_q;
    logic          tick;
    logic          entering;
    logic          zbit;

    logic sioc_q, siod_o_q, siod_oe_q, resend_q, advance_q, busy_q, done_q;
    logic sioc_d, siod_o_d, siod_oe_d, resend_d, advance_d, busy_d, done_d;

    assign entering = (state_d != state_q);
    assign zbit     = (bit_q == 5'd8) || (bit_q == 5'd17) || (bit_q == 5'd26);

    sccb_quarter_tick #(
        .QUARTER_DIV (QUARTER_DIV)
    ) u_tick (
        .clk     (clk),
        .rst     (rst),
        .clear_i (entering),
        .tick_o  (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RESTART;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RESTART:  state_d = ST_PWR_WAIT;
            ST_PWR_WAIT: if (wait_q == PW_LAST) state_d = ST_FETCH;
            ST_FETCH:    if (wait_q == FETCH_LAST) state_d = ST_CHECK;
            ST_CHECK:    state_d = bus.finished ? ST_DONE : ST_START;
            ST_START:    if (tick && qidx_q == 2'd2) state_d = ST_BITS;
            ST_BITS:     if (tick && qidx_q == 2'd3 && bit_q == LAST_BIT) state_d = ST_STOP;
            ST_STOP:     if (tick && qidx_q == 2'd3) state_d = ST_STEP;
            ST_STEP:     state_d = ST_GAP;
            ST_GAP:      if (wait_q == (com7_q ? RW_LAST : CG_LAST)) state_d = ST_FETCH;
            ST_DONE:     if (bus.reconfig) state_d = ST_RESTART;
            default:     state_d = ST_RESTART;
        endcase
    end

    // Wait/quarter/bit counters restart on every state entry; Z slots shift in as 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_q  <= '0;
            qidx_q  <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            com7_q  <= 1'b0;
        end else begin
            if (entering) begin
                wait_q <= '0;
                qidx_q <= '0;
                bit_q  <= '0;
            end else begin
                if (state_q == ST_PWR_WAIT || state_q == ST_FETCH || state_q == ST_GAP) begin
                    wait_q <= wait_q + WW'(1);
                end
                if (tick) begin
                    qidx_q <= qidx_q + 2'd1;
                    if (state_q == ST_BITS && qidx_q == 2'd3) begin
                        bit_q   <= bit_q + 5'd1;
                        shreg_q <= {shreg_q[25:0], 1'b1};
                    end
                end
            end
            if (state_q == ST_CHECK && !bus.finished) begin
                shreg_q <= {CAM_ID, 1'b1, bus.command[15:8], 1'b1, bus.command[7:0], 1'b1};
                com7_q  <= (bus.command[15:8] == COM7_ADDR) && bus.command[7];
            end
        end
    end

    always_comb begin
        sioc_d    = 1'b1;
        siod_o_d  = 1'b1;
        siod_oe_d = 1'b0;
        resend_d  = 1'b0;
        advance_d = 1'b0;
        busy_d    = (state_q != ST_DONE);
        done_d    = (state_q == ST_DONE);
        case (state_q)
            ST_RESTART: resend_d = 1'b1;
            ST_START: begin
                siod_oe_d = 1'b1;
                siod_o_d  = (qidx_q != 2'd2);
            end
            ST_BITS: begin
                sioc_d    = qidx_q[1];
                siod_oe_d = !zbit;
                siod_o_d  = shreg_q[26];
            end
            ST_STOP: begin
                sioc_d    = (qidx_q != 2'd0);
                siod_oe_d = (qidx_q != 2'd3);
                siod_o_d  = qidx_q[1];
            end
            ST_STEP: advance_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sioc_q    <= 1'b1;
            siod_o_q  <= 1'b1;
            siod_oe_q <= 1'b0;
            resend_q  <= 1'b0;
            advance_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            sioc_q    <= sioc_d;
            siod_o_q  <= siod_o_d;
            siod_oe_q <= siod_oe_d;
            resend_q  <= resend_d;
            advance_q <= advance_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.sioc        = sioc_q;
    assign bus.siod_o      = siod_o_q;
    assign bus.siod_oe     = siod_oe_q;
    assign bus.resend      = resend_q;
    assign bus.advance     = advance_q;
    assign bus.busy        = busy_q;
    assign bus.config_done = done_q;
endmodule
`default_nettype wire
